dtl_loader_slave: RTL

//  DTL target (responder) for the host-side loader control window of the CGRA.
//  It accepts single or burst DTL read/write commands from the host initiator
//  and decodes them into a small register map: config start, core reset release,

---
 rtl/dtl_loader_slave_pkg.sv | 41 ++++
 rtl/dtl_loader_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dtl_loader_slave_pkg.sv
// Shared definitions for the DTL loader control window: register offsets,
// FSM states, register selectors and status bit positions.
package dtl_loader_slave_pkg;

  localparam logic [31:0] OFF_CTRL      = 32'd0;
  localparam logic [31:0] OFF_RUN       = 32'd4;
  localparam logic [31:0] OFF_STATE_CMD = 32'd8;
  localparam logic [31:0] OFF_RADDR     = 32'd12;
  localparam logic [31:0] OFF_WADDR     = 32'd16;

  localparam int unsigned ST_DONE   = 0;
  localparam int unsigned ST_HALTED = 1;
  localparam int unsigned ST_BUSY   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_e;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_RUN,
    REG_CMD,
    REG_RADDR,
    REG_WADDR,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic [31:0] off);
    case (off)
      OFF_CTRL:      return REG_CTRL;
      OFF_RUN:       return REG_RUN;
      OFF_STATE_CMD: return REG_CMD;
      OFF_RADDR:     return REG_RADDR;
      OFF_WADDR:     return REG_WADDR;
      default:       return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dtl_loader_slave.sv
// DTL target for the CGRA loader control window (config start, core reset,
// state command/addresses, status). DTL_LOADER_BURST_EN enables multi-beat bursts.
module dtl_loader_slave
  import dtl_loader_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR             = 32'hC0000,
  parameter int unsigned INTERFACE_WIDTH       = 32,
  parameter int unsigned INTERFACE_ADDR_WIDTH  = 32,
  parameter int unsigned INTERFACE_BLOCK_WIDTH = 5,
  parameter int unsigned STATE_CMD_WIDTH       = 6
) (
  input  logic                               iClk,
  input  logic                               iReset,
  input  logic                               iDTL_CommandValid,
  output logic                               oDTL_CommandAccept,
  input  logic                               iDTL_CommandReadWrite,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]    iDTL_Address,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0]   iDTL_BlockSize,
  input  logic                               iDTL_WriteValid,
  output logic                               oDTL_WriteAccept,
  input  logic [INTERFACE_WIDTH-1:0]         iDTL_WriteData,
  input  logic [INTERFACE_WIDTH/8-1:0]       iDTL_WriteEnable,
  input  logic                               iDTL_WriteLast,
  output logic                               oDTL_ReadValid,
  input  logic                               iDTL_ReadAccept,
  output logic [INTERFACE_WIDTH-1:0]         oDTL_ReadData,
  output logic                               oDTL_ReadLast,
  input  logic                               iConfigDone,
  input  logic                               iHalted,
  output logic                               oConfigStart,
  output logic                               oCoreReset,
  output logic [STATE_CMD_WIDTH-1:0]         oStateCmd,
  output logic [INTERFACE_WIDTH-1:0]         oStateReadAddr,
  output logic [INTERFACE_WIDTH-1:0]         oStateWriteAddr
);

  localparam int unsigned DW   = INTERFACE_WIDTH;
  localparam int unsigned AW   = INTERFACE_ADDR_WIDTH;
  localparam int unsigned BW   = INTERFACE_BLOCK_WIDTH;
  localparam int unsigned BE_W = INTERFACE_WIDTH / 8;

  state_e                     state_q, state_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [BW-1:0]              cnt_q, cnt_d;
  logic [DW-1:0]              rdata_q, rdata_d;
  logic                       busy_q, busy_d;
  logic                       done_prev_q;
  logic                       start_q, start_d;
  logic                       run_q, run_d;
  logic [STATE_CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [DW-1:0]              raddr_q, raddr_d;
  logic [DW-1:0]              waddr_q, waddr_d;

  logic                       wr_en;
  logic                       done_rise;
  logic [AW-1:0]              rd_addr;
  logic [DW-1:0]              rd_mux;
  logic [BW-1:0]              beats_m1;
  reg_sel_e                   wr_sel;

`ifdef DTL_LOADER_BURST_EN
  logic unused_inputs;
  assign unused_inputs = iDTL_WriteLast;
  assign beats_m1      = iDTL_BlockSize;
`else
  logic unused_inputs;
  assign unused_inputs = iDTL_WriteLast ^ (^iDTL_BlockSize);
  assign beats_m1      = '0;
`endif

  // Read data is registered one beat ahead: at command accept from the command
  // address, and on each ReadAccept from the following word.
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? iDTL_Address : addr_q + AW'(4);
    rd_mux  = '0;
    unique case (decode(32'(rd_addr - BASE_ADDR)))
      REG_CTRL: begin
        rd_mux[ST_DONE]   = iConfigDone;
        rd_mux[ST_HALTED] = iHalted;
        rd_mux[ST_BUSY]   = busy_q;
      end
      REG_RUN:   rd_mux[0] = run_q;
      REG_CMD:   rd_mux[STATE_CMD_WIDTH-1:0] = cmd_q;
      REG_RADDR: rd_mux = raddr_q;
      REG_WADDR: rd_mux = waddr_q;
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    cnt_d              = cnt_q;
    rdata_d            = rdata_q;
    wr_en              = 1'b0;
    oDTL_CommandAccept = 1'b0;
    oDTL_WriteAccept   = 1'b0;
    oDTL_ReadValid     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        oDTL_CommandAccept = 1'b1;
        if (iDTL_CommandValid) begin
          addr_d = iDTL_Address;
          cnt_d  = beats_m1;
          if (iDTL_CommandReadWrite) begin
            state_d = S_READ;
            rdata_d = rd_mux;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        oDTL_WriteAccept = 1'b1;
        if (iDTL_WriteValid) begin
          wr_en  = 1'b1;
          addr_d = addr_q + AW'(4);
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - BW'(1);
        end
      end
      S_READ: begin
        oDTL_ReadValid = 1'b1;
        if (iDTL_ReadAccept) begin
          addr_d = addr_q + AW'(4);
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            rdata_d = '0;
          end else begin
            cnt_d   = cnt_q - BW'(1);
            rdata_d = rd_mux;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A config-done rising edge clears busy before any CTRL write is considered.
  always_comb begin
    wr_sel    = decode(32'(addr_q - BASE_ADDR));
    done_rise = iConfigDone & ~done_prev_q;
    start_d   = wr_en && (wr_sel == REG_CTRL) && !busy_q && !done_rise;
    busy_d    = start_d | (busy_q & ~done_rise);
    run_d     = run_q;
    cmd_d     = cmd_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    if (wr_en) begin
      unique case (wr_sel)
        REG_RUN: if (iDTL_WriteEnable[0]) run_d = iDTL_WriteData[0];
        REG_CMD: if (iDTL_WriteEnable[0]) cmd_d = iDTL_WriteData[STATE_CMD_WIDTH-1:0];
        REG_RADDR:
          for (int unsigned b = 0; b < BE_W; b++)
            if (iDTL_WriteEnable[b]) raddr_d[8*b +: 8] = iDTL_WriteData[8*b +: 8];
        REG_WADDR:
          for (int unsigned b = 0; b < BE_W; b++)
            if (iDTL_WriteEnable[b]) waddr_d[8*b +: 8] = iDTL_WriteData[8*b +: 8];
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_prev_q <= 1'b0;
      start_q     <= 1'b0;
      run_q       <= 1'b1;
      cmd_q       <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_prev_q <= iConfigDone;
      start_q     <= start_d;
      run_q       <= run_d;
      cmd_q       <= cmd_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
    end
  end

  assign oDTL_ReadData   = rdata_q;
  assign oDTL_ReadLast   = oDTL_ReadValid && (cnt_q == '0);
  assign oConfigStart    = start_q;
  assign oCoreReset      = run_q;
  assign oStateCmd       = cmd_q;
  assign oStateReadAddr  = raddr_q;
  assign oStateWriteAddr = waddr_q;

endmodule
